// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the integer register file and its load
// scoreboard.
//   REG_NUM  : number of architectural registers
//   REG_AW   : register address width
//   ZERO_REG : hard-wired zero register index
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int REG_NUM = 32;
  localparam int REG_AW  = 5;
  localparam int XLEN    = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   word_t;

  localparam reg_addr_t ZERO_REG = reg_addr_t'(0);

  // True for any register that holds state (everything except r0).
  function automatic logic is_live(input reg_addr_t addr);
    return addr != ZERO_REG;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// Tracks registers that are the destination of an issued, not yet written
// back, load. One pending bit per register; bit 0 is tied low.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   set_i/set_addr_i  : mark a register pending (load issued)
//   clr_i/clr_addr_i  : clear a register's pending mark (writeback)
//   flush_i           : clear every pending mark
//   raddrN_i/busyN_o  : lookup ports; busy masked by same-cycle writeback
//                       when BYPASS=1, forced low during reset
//   pending_o         : full pending vector, for observation
// -----------------------------------------------------------------------------
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_i,
  input  reg_addr_t          set_addr_i,
  input  logic               clr_i,
  input  reg_addr_t          clr_addr_i,
  input  logic               flush_i,
  input  reg_addr_t          raddr1_i,
  input  reg_addr_t          raddr2_i,
  output logic               busy1_o,
  output logic               busy2_o,
  output logic [REG_NUM-1:0] pending_o
);

  logic [REG_NUM-1:0] pending_q;
  logic [REG_NUM-1:0] pending_d;
  logic               fwd1;
  logic               fwd2;

  // Clear is applied before set so that a load issued in the same cycle as
  // an older writeback to that register stays outstanding. Flush overrides.
  always_comb begin
    pending_d = pending_q;
    if (clr_i && is_live(clr_addr_i)) pending_d[clr_addr_i] = 1'b0;
    if (set_i && is_live(set_addr_i)) pending_d[set_addr_i] = 1'b1;
    if (flush_i)                      pending_d = '0;
    pending_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending_q <= '0;
    else      pending_q <= pending_d;
  end

  // A writeback landing this cycle is already forwarded on the data path,
  // so the reader need not stall on it.
  assign fwd1 = BYPASS && clr_i && (clr_addr_i == raddr1_i);
  assign fwd2 = BYPASS && clr_i && (clr_addr_i == raddr2_i);

  assign busy1_o   = rst && pending_q[raddr1_i] && !fwd1;
  assign busy2_o   = rst && pending_q[raddr2_i] && !fwd2;
  assign pending_o = pending_q;

endmodule

// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile
// 32 x 32-bit register file, two combinational read ports, one write port,
// optional write-to-read forwarding, plus a load scoreboard.
// Ports:
//   clk, rst                : clock, asynchronous active-low reset
//   rf_wen_i/rf_waddr_i/
//   rf_wdata_i              : writeback port (only waddr[4:0] decoded)
//   rf_raddrN_i/rf_rdataN_o : read ports 1 and 2
//   sb_set_i/sb_setaddr_i   : mark a load destination pending
//   sb_flush_i              : clear all pending marks
//   rf_busyN_o              : read register has an outstanding load
// There is no valid/ready handshake: every input is sampled on each rising
// edge, and outputs are pure combinational functions of state and inputs.
// -----------------------------------------------------------------------------
module regfile
  import regfile_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rf_wen_i,
  input  logic [31:0] rf_waddr_i,
  input  logic [31:0] rf_wdata_i,
  input  logic [4:0]  rf_raddr1_i,
  input  logic [4:0]  rf_raddr2_i,
  output logic [31:0] rf_rdata1_o,
  output logic [31:0] rf_rdata2_o,
  input  logic        sb_set_i,
  input  logic [4:0]  sb_setaddr_i,
  input  logic        sb_flush_i,
  output logic        rf_busy1_o,
  output logic        rf_busy2_o
);

  word_t              regs_q [REG_NUM];
  reg_addr_t          waddr;
  logic               we_live;
  logic [REG_NUM-1:0] unused_pending;
  logic               unused_waddr_hi;

  // Upper address bits are deliberately ignored: 0x20 aliases r0.
  assign waddr           = rf_waddr_i[REG_AW-1:0];
  assign unused_waddr_hi = ^rf_waddr_i[31:REG_AW];
  assign we_live         = rf_wen_i && is_live(waddr);

  // r0 is reset and never written, so it always reads zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else if (we_live) begin
      regs_q[waddr] <= rf_wdata_i;
    end
  end

  // Reads are gated by reset so forwarded write data cannot leak out while
  // the array is being held clear.
  always_comb begin
    rf_rdata1_o = '0;
    if (rst && is_live(rf_raddr1_i)) begin
      if (BYPASS && we_live && (waddr == rf_raddr1_i)) rf_rdata1_o = rf_wdata_i;
      else                                             rf_rdata1_o = regs_q[rf_raddr1_i];
    end
  end

  always_comb begin
    rf_rdata2_o = '0;
    if (rst && is_live(rf_raddr2_i)) begin
      if (BYPASS && we_live && (waddr == rf_raddr2_i)) rf_rdata2_o = rf_wdata_i;
      else                                             rf_rdata2_o = regs_q[rf_raddr2_i];
    end
  end

  rf_scoreboard #(
    .BYPASS (BYPASS)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_i      (sb_set_i),
    .set_addr_i (sb_setaddr_i),
    .clr_i      (rf_wen_i),
    .clr_addr_i (waddr),
    .flush_i    (sb_flush_i),
    .raddr1_i   (rf_raddr1_i),
    .raddr2_i   (rf_raddr2_i),
    .busy1_o    (rf_busy1_o),
    .busy2_o    (rf_busy2_o),
    .pending_o  (unused_pending)
  );

endmodule

// File: tb/tb_regfile.sv
// -----------------------------------------------------------------------------
// tb_regfile
// Drives one BYPASS=1 and one BYPASS=0 register file from the same inputs and
// checks both against a behavioural model (register array + pending bits).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_regfile;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        wen;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1, raddr2;
  logic        sb_set;
  logic [4:0]  sb_setaddr;
  logic        sb_flush;
  logic [31:0] rdata1_b, rdata2_b, rdata1_n, rdata2_n;
  logic        busy1_b, busy2_b, busy1_n, busy2_n;

  regfile #(.BYPASS(1'b1)) dut_byp (
    .clk(clk), .rst(rst),
    .rf_wen_i(wen), .rf_waddr_i(waddr), .rf_wdata_i(wdata),
    .rf_raddr1_i(raddr1), .rf_raddr2_i(raddr2),
    .rf_rdata1_o(rdata1_b), .rf_rdata2_o(rdata2_b),
    .sb_set_i(sb_set), .sb_setaddr_i(sb_setaddr), .sb_flush_i(sb_flush),
    .rf_busy1_o(busy1_b), .rf_busy2_o(busy2_b)
  );

  regfile #(.BYPASS(1'b0)) dut_nob (
    .clk(clk), .rst(rst),
    .rf_wen_i(wen), .rf_waddr_i(waddr), .rf_wdata_i(wdata),
    .rf_raddr1_i(raddr1), .rf_raddr2_i(raddr2),
    .rf_rdata1_o(rdata1_n), .rf_rdata2_o(rdata2_n),
    .sb_set_i(sb_set), .sb_setaddr_i(sb_setaddr), .sb_flush_i(sb_flush),
    .rf_busy1_o(busy1_n), .rf_busy2_o(busy2_n)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_mem [32];
  logic [31:0] m_pend;

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_pend = '0;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (!rst || a == 5'd0) return 32'h0;
    if (byp && wen && waddr[4:0] == a) return wdata;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (!rst || a == 5'd0) return 1'b0;
    if (byp && wen && waddr[4:0] == a) return 1'b0;
    return m_pend[a];
  endfunction

  // Advance one rising edge, applying the architectural rules to the model,
  // then return to the falling edge.
  task automatic tick();
    logic [4:0] wa;
    @(posedge clk);
    wa = waddr[4:0];
    if (rst) begin
      if (wen && wa != 5'd0) m_mem[wa] = wdata;
      if (sb_flush) m_pend = '0;
      else begin
        if (wen && wa != 5'd0) m_pend[wa] = 1'b0;
        if (sb_set && sb_setaddr != 5'd0) m_pend[sb_setaddr] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wen = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    sb_set = 1'b0; sb_setaddr = '0; sb_flush = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    model_clear();
    #2;
    wen = 1'b1; waddr = 32'd4; wdata = 32'hCAFE_F00D;
    raddr1 = 5'd4; raddr2 = 5'd4; sb_set = 1'b1; sb_setaddr = 5'd4;
    #1;
    checks++;
    if ({rdata1_b, rdata2_b, rdata1_n, rdata2_n} !== 128'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h %h %h %h exp=0", rdata1_b, rdata2_b, rdata1_n, rdata2_n);
    end
    checks++;
    if ({busy1_b, busy2_b, busy1_n, busy2_n} !== 4'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b%b%b%b exp=0000", busy1_b, busy2_b, busy1_n, busy2_n);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    wen = 1'b1; waddr = 32'd5; wdata = 32'hDEAD_BEEF; raddr1 = 5'd1;
    tick();
    wen = 1'b0; raddr1 = 5'd5;
    #1;
    checks++;
    if (rdata1_b !== 32'hDEAD_BEEF || rdata1_n !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL write_read_r5 got=%h/%h exp=deadbeef", rdata1_b, rdata1_n);
    end
  endtask

  task automatic test_r0_and_alias();
    wen = 1'b1; waddr = 32'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0; raddr2 = 5'd0;
    sb_set = 1'b1; sb_setaddr = 5'd0;
    #1;
    checks++;
    if (rdata1_b !== 32'h0 || rdata2_b !== 32'h0) begin
      failures++;
      $display("FAIL r0_no_bypass got=%h/%h exp=0", rdata1_b, rdata2_b);
    end
    tick();
    wen = 1'b0; sb_set = 1'b0;
    #1;
    checks++;
    if (rdata1_b !== 32'h0 || rdata1_n !== 32'h0 || busy1_b !== 1'b0 || busy1_n !== 1'b0) begin
      failures++;
      $display("FAIL r0_read got=%h/%h busy=%b/%b exp=0 busy=0", rdata1_b, rdata1_n, busy1_b, busy1_n);
    end
    // 0x20 aliases r0; 0xFFFFFFE3 aliases r3.
    wen = 1'b1; waddr = 32'h0000_0020; wdata = 32'hAAAA_5555;
    tick();
    waddr = 32'hFFFF_FFE3; wdata = 32'h3333_0003;
    tick();
    wen = 1'b0; raddr1 = 5'd0; raddr2 = 5'd3;
    #1;
    checks++;
    if (rdata1_n !== 32'h0 || rdata2_n !== 32'h3333_0003) begin
      failures++;
      $display("FAIL waddr_upper_bits got r0=%h r3=%h exp r0=0 r3=33330003", rdata1_n, rdata2_n);
    end
  endtask

  task automatic test_bypass();
    wen = 1'b1; waddr = 32'd7; wdata = 32'h1111_1111;
    tick();
    wen = 1'b1; waddr = 32'd7; wdata = 32'h1234_5678; raddr2 = 5'd7;
    #1;
    checks++;
    if (rdata2_b !== 32'h1234_5678) begin
      failures++;
      $display("FAIL bypass_on_same_cycle got=%h exp=12345678", rdata2_b);
    end
    checks++;
    if (rdata2_n !== 32'h1111_1111) begin
      failures++;
      $display("FAIL bypass_off_same_cycle got=%h exp=11111111", rdata2_n);
    end
    tick();
    wen = 1'b0;
    #1;
    checks++;
    if (rdata2_n !== 32'h1234_5678) begin
      failures++;
      $display("FAIL bypass_off_next_cycle got=%h exp=12345678", rdata2_n);
    end
  endtask

  task automatic test_scoreboard();
    sb_set = 1'b1; sb_setaddr = 5'd9;
    tick();
    sb_set = 1'b0; raddr1 = 5'd9;
    #1;
    checks++;
    if (busy1_b !== 1'b1 || busy1_n !== 1'b1) begin
      failures++;
      $display("FAIL sb_busy_after_set got=%b/%b exp=1/1", busy1_b, busy1_n);
    end
    @(negedge clk);
    wen = 1'b1; waddr = 32'd9; wdata = 32'h0000_0999;
    #1;
    checks++;
    if (busy1_b !== 1'b0 || busy1_n !== 1'b1) begin
      failures++;
      $display("FAIL sb_busy_writeback got=%b/%b exp=0/1", busy1_b, busy1_n);
    end
    tick();
    wen = 1'b0;
    #1;
    checks++;
    if (busy1_b !== 1'b0 || busy1_n !== 1'b0) begin
      failures++;
      $display("FAIL sb_cleared got=%b/%b exp=0/0", busy1_b, busy1_n);
    end
  endtask

  task automatic test_set_clear_flush();
    sb_set = 1'b1; sb_setaddr = 5'd3; wen = 1'b1; waddr = 32'd3; wdata = 32'h0303_0303;
    tick();
    sb_set = 1'b0; wen = 1'b0; raddr1 = 5'd3;
    #1;
    checks++;
    if (busy1_b !== 1'b1 || busy1_n !== 1'b1) begin
      failures++;
      $display("FAIL set_wins_over_clear got=%b/%b exp=1/1", busy1_b, busy1_n);
    end
    @(negedge clk);
    sb_flush = 1'b1; sb_set = 1'b1; sb_setaddr = 5'd4;
    tick();
    sb_flush = 1'b0; sb_set = 1'b0; raddr2 = 5'd4;
    #1;
    checks++;
    if ({busy1_b, busy1_n, busy2_b, busy2_n} !== 4'b0000) begin
      failures++;
      $display("FAIL flush_overrides got=%b%b%b%b exp=0000", busy1_b, busy1_n, busy2_b, busy2_n);
    end
  endtask

  task automatic test_random();
    logic [31:0] e;
    logic        eb;
    for (int n = 0; n < 400; n++) begin
      wen        = 1'($urandom_range(0, 1));
      waddr      = $urandom();
      waddr[4:0] = 5'($urandom_range(0, 7));
      wdata      = $urandom();
      raddr1     = 5'($urandom_range(0, 7));
      raddr2     = 5'($urandom_range(0, 7));
      sb_set     = 1'($urandom_range(0, 2) == 0);
      sb_setaddr = 5'($urandom_range(0, 7));
      sb_flush   = 1'($urandom_range(0, 15) == 0);
      #1;
      e = exp_rd(raddr1, 1'b1); checks++;
      if (rdata1_b !== e) begin failures++; $display("FAIL rand_rdata1_byp n=%0d got=%h exp=%h", n, rdata1_b, e); end
      e = exp_rd(raddr2, 1'b1); checks++;
      if (rdata2_b !== e) begin failures++; $display("FAIL rand_rdata2_byp n=%0d got=%h exp=%h", n, rdata2_b, e); end
      e = exp_rd(raddr1, 1'b0); checks++;
      if (rdata1_n !== e) begin failures++; $display("FAIL rand_rdata1_nob n=%0d got=%h exp=%h", n, rdata1_n, e); end
      e = exp_rd(raddr2, 1'b0); checks++;
      if (rdata2_n !== e) begin failures++; $display("FAIL rand_rdata2_nob n=%0d got=%h exp=%h", n, rdata2_n, e); end
      eb = exp_busy(raddr1, 1'b1); checks++;
      if (busy1_b !== eb) begin failures++; $display("FAIL rand_busy1_byp n=%0d got=%b exp=%b", n, busy1_b, eb); end
      eb = exp_busy(raddr2, 1'b1); checks++;
      if (busy2_b !== eb) begin failures++; $display("FAIL rand_busy2_byp n=%0d got=%b exp=%b", n, busy2_b, eb); end
      eb = exp_busy(raddr1, 1'b0); checks++;
      if (busy1_n !== eb) begin failures++; $display("FAIL rand_busy1_nob n=%0d got=%b exp=%b", n, busy1_n, eb); end
      eb = exp_busy(raddr2, 1'b0); checks++;
      if (busy2_n !== eb) begin failures++; $display("FAIL rand_busy2_nob n=%0d got=%b exp=%b", n, busy2_n, eb); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    // Leave data and pending state behind, then reset between edges.
    wen = 1'b1; waddr = 32'd6; wdata = 32'h6666_6666; sb_set = 1'b1; sb_setaddr = 5'd2;
    tick();
    wen = 1'b1; waddr = 32'd2; wdata = 32'h2222_2222; raddr1 = 5'd6; raddr2 = 5'd2;
    sb_set = 1'b1; sb_setaddr = 5'd6;
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({rdata1_b, rdata2_b, rdata1_n, rdata2_n} !== 128'h0) begin
      failures++;
      $display("FAIL async_reset_rdata got=%h %h %h %h exp=0", rdata1_b, rdata2_b, rdata1_n, rdata2_n);
    end
    checks++;
    if ({busy1_b, busy2_b, busy1_n, busy2_n} !== 4'b0) begin
      failures++;
      $display("FAIL async_reset_busy got=%b%b%b%b exp=0000", busy1_b, busy2_b, busy1_n, busy2_n);
    end
    @(negedge clk);
    idle_inputs();
    wen = 1'b1; waddr = 32'd1; wdata = 32'h0000_0001; sb_set = 1'b1; sb_setaddr = 5'd8;
    #2;
    rst = 1'b1;
    tick();
    wen = 1'b0; sb_set = 1'b0; raddr1 = 5'd1; raddr2 = 5'd8;
    #1;
    checks++;
    if (rdata1_b !== 32'h1 || rdata1_n !== 32'h1) begin
      failures++;
      $display("FAIL post_reset_write got=%h/%h exp=00000001", rdata1_b, rdata1_n);
    end
    checks++;
    if (busy2_b !== 1'b1 || busy2_n !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_set got=%b/%b exp=1/1", busy2_b, busy2_n);
    end
    checks++;
    if (rdata2_b !== 32'h0 || rdata2_n !== 32'h0) begin
      failures++;
      $display("FAIL post_reset_cleared got=%h/%h exp=0", rdata2_b, rdata2_n);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_write_read();
    test_r0_and_alias();
    test_bypass();
    test_scoreboard();
    test_set_clear_flush();
    test_random();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter BYPASS, default 1: 1 enables same-cycle write-to-read forwarding; 0 disables it.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 rf_wen_i  in  1  write enable from writeback stage.
REQ-005 rf_waddr_i  in  32  write address; only bits [4:0] used, upper bits ignored.
REQ-006 rf_wdata_i  in  32  write data.
REQ-007 rf_raddr1_i / rf_raddr2_i  in  5 each  read addresses, ports 1 and 2.
REQ-008 rf_rdata1_o / rf_rdata2_o  out  32 each  read data, ports 1 and 2.
REQ-009 sb_set_i  in  1  decode issued a load; mark sb_setaddr_i pending.
REQ-010 sb_setaddr_i  in  5  destination of the issued load.
REQ-011 sb_flush_i  in  1  pipeline flush; clear all pending marks.
REQ-012 rf_busy1_o / rf_busy2_o  out  1 each  read register has an unresolved pending write.

Function
REQ-013 Storage SHALL be 32 x 32-bit registers; r0 SHALL always read 0, and writes to r0 SHALL be discarded.
REQ-014 Write SHALL commit on the rising edge when rf_wen_i=1 and rf_waddr_i[4:0]!=0; 1-cycle write latency.
REQ-015 Reads SHALL be combinational, 0-cycle latency; both ports independent and may address the same register.
REQ-016 BYPASS=1: rf_wen_i=1, waddr[4:0]==raddr and raddr!=0 -> rdata SHALL equal rf_wdata_i in the same cycle.
REQ-017 BYPASS=0: rdata SHALL be the stored value; a write is visible from the next cycle.
REQ-018 Scoreboard: 32-bit pending vector; bit 0 SHALL be constant 0.
REQ-019 Rising edge, sb_set_i=1 and sb_setaddr_i!=0 -> pending[sb_setaddr_i] set.
REQ-020 Rising edge, rf_wen_i=1 and waddr[4:0]!=0 -> pending[waddr[4:0]] cleared.
REQ-021 Set and clear to the same address in one cycle -> set wins; the newer load remains outstanding.
REQ-022 sb_flush_i=1 -> all pending bits cleared at the edge, overriding a simultaneous set or clear.
REQ-023 busyN = pending[raddrN] AND NOT (BYPASS=1 and a same-cycle write to raddrN); raddrN=0 -> busyN=0.
REQ-024 Writes while pending[addr]=0 are legal and SHALL update data only.
REQ-025 Unused upper write-address bits SHALL NOT affect addressing; 0x20 behaves as r0.

Reset
REQ-026 rst low SHALL immediately clear all 32 registers and the pending vector, regardless of clk.
REQ-027 During reset, rdata outputs SHALL be 0 and busy outputs SHALL be 0, whatever the inputs.
REQ-028 A write or set coincident with reset deassertion SHALL NOT be lost; the first edge after release commits normally.

Structure
REQ-029 The shared package SHALL hold REG_NUM=32, REG_AW=5 and ZERO_REG=0.
REQ-030 The scoreboard SHALL be a sub-module, rf_scoreboard, with set, clear, flush and two busy lookups; data array and bypass stay in regfile.

Verification
REQ-031 Write r5=0xDEADBEEF, then read r5 on port 1 next cycle -> 0xDEADBEEF.
REQ-032 Write r0=0xFFFFFFFF, then read r0 -> 0x00000000; busy=0.
REQ-033 BYPASS=1: same-cycle write r7=0x12345678 and raddr2=7 -> rdata2=0x12345678 that cycle. BYPASS=0 -> old value that cycle, new value next cycle.
REQ-034 sb_set r9, then read r9 -> busy1=1. Writeback r9 -> busy1=0 in that cycle (BYPASS=1), pending cleared next.
REQ-035 sb_set r3 and write r3 in the same cycle -> busy stays 1. Then sb_flush -> busy 0 next cycle.
REQ-036 Assert rst low mid-stream, asynchronously between edges -> all reads 0 and busy 0 at once. After release, write r1=0x1 -> reads 0x1.
